uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the data bits per character.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, SHALL set the start-acknowledge watchdog limit.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 reqValid  input  NUM_REQ  SHALL indicate that requester i holds a character to send.
REQ-007 reqData  input  NUM_REQ*WIDTH  SHALL carry the character for requester i in slice [i*WIDTH +: WIDTH].
REQ-008 reqReady  output  NUM_REQ  SHALL pulse one-hot for one cycle when requester i's character is accepted.
REQ-009 txData  output  WIDTH  SHALL drive the character to the UART transmitter.
REQ-010 txStart  output  1  SHALL be a one-cycle start strobe to the transmitter.
REQ-011 txBusy  input  1  SHALL be the transmitter's busy flag.
REQ-012 grantId  output  $clog2(NUM_REQ)  SHALL give the index of the current or last granted requester.
REQ-013 arbBusy  output  1  SHALL be high whenever the state is not IDLE.
REQ-014 timeoutErr  output  1  SHALL pulse for one cycle on a watchdog expiry.

Function
REQ-015 FSM states SHALL be IDLE, LAUNCH, WAIT_START and WAIT_DONE.
REQ-016 IDLE -> LAUNCH SHALL occur when any reqValid bit is 1 and txBusy is 0; otherwise the FSM remains in IDLE.
REQ-017 On that edge, the winner SHALL be the first requester with reqValid set, searching round-robin from lastGrant+1 and wrapping NUM_REQ-1 -> 0.
REQ-018 On that same edge, txData and grantId SHALL register the winner's data and index.
REQ-019 In LAUNCH, txStart and reqReady[grantId] SHALL be 1 for exactly one cycle; the next state is WAIT_START.
REQ-020 Latency SHALL be one cycle: reqValid sampled at edge k gives txStart high in cycle k+1.
REQ-021 WAIT_START -> WAIT_DONE SHALL occur on txBusy=1.
REQ-022 WAIT_DONE -> IDLE SHALL occur on txBusy=0, and lastGrant SHALL be updated to grantId on that edge.
REQ-023 Requesters SHALL hold reqValid and reqData stable until reqReady; a reqValid that drops before grant is simply not served.
REQ-024 A reqValid bit that rises while the FSM is not in IDLE SHALL wait, with no reqReady issued.
REQ-025 txData SHALL be held constant from LAUNCH through WAIT_DONE.
REQ-026 If only one requester is valid, it SHALL be granted back-to-back; the minimum spacing between grants is one idle cycle.

Reset
REQ-027 Reset SHALL force state=IDLE, txStart=0, reqReady=0, txData=0, grantId=0, arbBusy=0, timeoutErr=0, and lastGrant=NUM_REQ-1, so that requester 0 has first priority.
REQ-028 Reset asserted mid-operation SHALL abandon the character immediately, with no further txStart or reqReady.

Configuration
REQ-029 With UART_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT_START and clear elsewhere. On reaching TIMEOUT_CYCLES-1 without txBusy, it SHALL pulse timeoutErr and return the FSM to IDLE, updating lastGrant.
REQ-030 Without UART_ARB_TIMEOUT_EN, WAIT_START SHALL wait indefinitely, timeoutErr SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-031 Package uart_pkg SHALL hold the arbiter state enum, the default WIDTH and the clog2-based index-width localparam.
REQ-032 Round-robin selection SHALL live in sub-module rr_picker: inputs reqValid and lastGrant; outputs winner index and an anyValid flag; purely combinational.

Verification
REQ-033 Single request: reqValid=4'b0001 with data 0x55 -> txStart is one cycle later with txData=0x55; reqReady=4'b0001 for exactly one cycle.
REQ-034 Contention: all four requesters valid with 0xA0..0xA3 -> grant order 0,1,2,3,0 with matching txData; each grant waits for txBusy to fall.
REQ-035 Busy block: txBusy=1 held while reqValid=4'b0100 -> no txStart until txBusy falls; then grant requester 2.
REQ-036 Reset mid-WAIT_DONE: assert reset -> all outputs are 0 within the same cycle; after release, requester 0 wins over 3.
REQ-037 Timeout (macro on, TIMEOUT_CYCLES=16): txBusy never rises -> timeoutErr pulses 16 cycles after txStart; the FSM returns to IDLE and the next requester is served.
REQ-038 Back-to-back via the uartReceiver loopback at 115200 baud and 50 MHz: bytes 0x12 and 0x34 from two requesters -> both are received in grant order.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

   // Arbiter FSM states; the encoding is also exported on the debug port.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LAUNCH     = 2'd1,
      WAIT_START = 2'd2,
      WAIT_DONE  = 2'd3
   } arbState_t;

   localparam int DEFAULT_WIDTH   = 8;
   localparam int DEFAULT_NUM_REQ = 4;

   // Width of a requester index; NUM_REQ is always at least 2.
   localparam int DEFAULT_IDX_W   = $clog2(DEFAULT_NUM_REQ);

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first valid requester after lastGrant,
// wrapping from NUM_REQ-1 back to 0.
module rr_picker
   import uart_pkg::*;
#(
   parameter int NUM_REQ = DEFAULT_NUM_REQ,
   parameter int IDX_W   = DEFAULT_IDX_W
)(
   input  logic [NUM_REQ-1:0] reqValid,
   input  logic [IDX_W-1:0]   lastGrant,
   output logic [IDX_W-1:0]   winner,
   output logic               anyValid
);

   // Walk the requesters in priority order starting just after lastGrant.
   always_comb begin
      int idx;
      winner   = '0;
      anyValid = 1'b0;
      idx      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(lastGrant) + k;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         if (!anyValid && reqValid[IDX_W'(idx)]) begin
            winner   = IDX_W'(idx);
            anyValid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters.
// Optional start-acknowledge watchdog enabled by defining UART_ARB_TIMEOUT_EN.
//
// Handshake: a requester holds reqValid/reqData stable until it sees a
// one-cycle reqReady pulse; that pulse coincides with the txStart strobe that
// hands its character to the transmitter, which then answers via txBusy.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = DEFAULT_NUM_REQ,
   parameter int WIDTH          = DEFAULT_WIDTH,
   parameter int TIMEOUT_CYCLES = 1024
)(
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         reqValid,
   input  logic [NUM_REQ*WIDTH-1:0]   reqData,
   output logic [NUM_REQ-1:0]         reqReady,
   output logic [WIDTH-1:0]           txData,
   output logic                       txStart,
   input  logic                       txBusy,
   output logic [$clog2(NUM_REQ)-1:0] grantId,
   output logic                       arbBusy,
   output logic                       timeoutErr,
   output logic [1:0]                 dbgState
);

   localparam int IDX_W = $clog2(NUM_REQ);

   arbState_t        state;
   arbState_t        nextState;
   logic [IDX_W-1:0] lastGrant;
   logic [IDX_W-1:0] winner;
   logic             anyValid;
   logic [WIDTH-1:0] winData;
   logic             loadGrant;
   logic             releaseGrant;
   logic             toExpire;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) uPicker (
      .reqValid  (reqValid),
      .lastGrant (lastGrant),
      .winner    (winner),
      .anyValid  (anyValid)
   );

   // Select the winning requester's character from the packed data bus.
   always_comb begin
      winData = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) begin
            winData = reqData[i*WIDTH +: WIDTH];
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] toCnt;

   // Watchdog counts cycles spent in WAIT_START and clears in every other state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         toCnt <= '0;
      end else if (state == WAIT_START) begin
         toCnt <= toCnt + 1'b1;
      end else begin
         toCnt <= '0;
      end
   end

   assign toExpire = (state == WAIT_START) && !txBusy &&
                     (toCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   // No watchdog in this build; TIMEOUT_CYCLES has no effect and the
   // comparison below is constant false for any legal value.
   assign toExpire = (TIMEOUT_CYCLES < 0);
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic plus the grant load/release strobes.
   always_comb begin
      nextState    = state;
      loadGrant    = 1'b0;
      releaseGrant = 1'b0;
      case (state)
         IDLE: begin
            if (anyValid && !txBusy) begin
               nextState = LAUNCH;
               loadGrant = 1'b1;
            end
         end
         LAUNCH: begin
            nextState = WAIT_START;
         end
         WAIT_START: begin
            if (txBusy) begin
               nextState = WAIT_DONE;
            end else if (toExpire) begin
               nextState    = IDLE;
               releaseGrant = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (!txBusy) begin
               nextState    = IDLE;
               releaseGrant = 1'b1;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Grant datapath: capture winner on launch, advance priority on release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txData    <= '0;
         grantId   <= '0;
         lastGrant <= IDX_W'(NUM_REQ - 1);
      end else begin
         if (loadGrant) begin
            txData  <= winData;
            grantId <= winner;
         end
         if (releaseGrant) begin
            lastGrant <= grantId;
         end
      end
   end

   // Strobes decode straight from state so reset silences them immediately.
   always_comb begin
      txStart    = (state == LAUNCH);
      reqReady   = (state == LAUNCH) ? (NUM_REQ'(1) << grantId) : '0;
      arbBusy    = (state != IDLE);
      timeoutErr = toExpire;
      dbgState   = state;
   end

endmodule
